// File: rtl/cis_scan_scheduler.sv
// cis_scan_scheduler: line/frame sequencer for the CIS exposure controller.
// Produces the sensor start pulse, scan/frame strobes, R/G/B phase stepping,
// per-frame line counting and exposure-overrun detection. Config is sampled
// only when a start is accepted and held in shadow registers for the scan.
module cis_scan_scheduler #(
    parameter int CNT_W      = 16,
    parameter int SPW_W      = 8,
    parameter int MIN_PERIOD = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_continuous,
    input  logic             i_color_mode,
    input  logic [CNT_W-1:0] i_line_period,
    input  logic [SPW_W-1:0] i_sp_width,
    input  logic [CNT_W-1:0] i_lines_per_frame,
    input  logic             i_led_oe_n,
    output logic             o_sp,
    output logic             o_pos_start,
    output logic             o_pos_frame,
    output logic [1:0]       o_color_phase,
    output logic [CNT_W-1:0] o_line_cnt,
    output logic             o_frame_done,
    output logic             o_busy,
    output logic             o_cfg_err,
    output logic             o_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_PERIOD);

    // Registered state and outputs
    state_t           r_state;
    logic [CNT_W-1:0] r_period_cnt;
    logic [1:0]       r_phase;
    logic [CNT_W-1:0] r_line_cnt;
    logic             r_sp;
    logic             r_pos_start;
    logic             r_pos_frame;
    logic             r_frame_done;
    logic             r_busy;
    logic             r_cfg_err;
    logic             r_overrun;

    // Shadow copies of the configuration, frozen for the whole scan
    logic             r_sh_color;
    logic             r_sh_cont;
    logic [CNT_W-1:0] r_sh_period;
    logic [SPW_W-1:0] r_sh_spw;
    logic [CNT_W-1:0] r_sh_lpf;

    // Next-state values
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_period_cnt_nxt;
    logic [1:0]       w_phase_nxt;
    logic [CNT_W-1:0] w_line_cnt_nxt;
    logic             w_sp_nxt;
    logic             w_pos_start_nxt;
    logic             w_pos_frame_nxt;
    logic             w_frame_done_nxt;
    logic             w_busy_nxt;
    logic             w_cfg_err_nxt;
    logic             w_overrun_nxt;
    logic             w_accept;

    // Decoded conditions
    logic             w_active;
    logic             w_cfg_ok;
    logic             w_period_end;
    logic             w_line_done;
    logic             w_last_line;
    logic [CNT_W-1:0] w_spw_in_ext;
    logic [CNT_W-1:0] w_spw_sh_ext;

    assign w_spw_in_ext = {{(CNT_W-SPW_W){1'b0}}, i_sp_width};
    assign w_spw_sh_ext = {{(CNT_W-SPW_W){1'b0}}, r_sh_spw};

    assign w_cfg_ok = (i_line_period >= CNT_MIN) &&
                      (i_sp_width != {SPW_W{1'b0}}) &&
                      (w_spw_in_ext < i_line_period) &&
                      (i_lines_per_frame != CNT_ZERO);

    assign w_active     = (r_state != ST_IDLE);
    assign w_period_end = w_active && (r_period_cnt == (r_sh_period - CNT_ONE));
    // A line ends on every period in gray mode, and on the B period in colour mode
    assign w_line_done  = w_period_end && (!r_sh_color || (r_phase == 2'd2));
    assign w_last_line  = w_line_done && ((r_line_cnt + CNT_ONE) == r_sh_lpf);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt      = r_state;
        w_period_cnt_nxt = r_period_cnt;
        w_phase_nxt      = r_phase;
        w_line_cnt_nxt   = r_line_cnt;
        w_pos_start_nxt  = 1'b0;
        w_pos_frame_nxt  = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_cfg_err_nxt    = 1'b0;
        w_overrun_nxt    = r_overrun;
        w_accept         = 1'b0;
        w_sp_nxt         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_phase_nxt = 2'd0;
                if (i_start) begin
                    if (w_cfg_ok) begin
                        w_accept         = 1'b1;
                        w_state_nxt      = ST_RUN;
                        w_pos_start_nxt  = 1'b1;
                        w_pos_frame_nxt  = 1'b1;
                        w_period_cnt_nxt = CNT_ZERO;
                        w_line_cnt_nxt   = CNT_ZERO;
                        w_overrun_nxt    = 1'b0;
                    end else begin
                        w_cfg_err_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_RUN, ST_STOPPING: begin
                // Period counter and colour phase stepping
                if (w_period_end) begin
                    w_period_cnt_nxt = CNT_ZERO;
                    if (r_sh_color && (r_phase != 2'd2)) begin
                        w_phase_nxt = r_phase + 2'd1;
                    end else begin
                        w_phase_nxt = 2'd0;
                    end
                end else begin
                    w_period_cnt_nxt = r_period_cnt + CNT_ONE;
                end

                // Exposure still running when the period closes
                if (w_period_end && !i_led_oe_n) begin
                    w_overrun_nxt = 1'b1;
                end else begin
                    w_overrun_nxt = r_overrun;
                end

                // Line count shows the final value for the frame_done cycle, then clears
                if (w_line_done) begin
                    w_line_cnt_nxt   = r_line_cnt + CNT_ONE;
                    w_frame_done_nxt = w_last_line;
                end else if (r_frame_done) begin
                    w_line_cnt_nxt = CNT_ZERO;
                end else begin
                    w_line_cnt_nxt = r_line_cnt;
                end

                // Scan termination, frame wrap and stop requests
                if (w_line_done &&
                    ((r_state == ST_STOPPING) || i_stop || (w_last_line && !r_sh_cont))) begin
                    w_state_nxt      = ST_IDLE;
                    w_period_cnt_nxt = CNT_ZERO;
                    w_phase_nxt      = 2'd0;
                end else if (w_last_line) begin
                    w_pos_frame_nxt = 1'b1;
                end else if ((r_state == ST_RUN) && i_stop) begin
                    w_state_nxt = ST_STOPPING;
                end else begin
                    w_state_nxt = r_state;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // sp follows the next period count so it rises together with period_cnt==0
        if (w_accept) begin
            w_sp_nxt = 1'b1;
        end else if (w_active && (w_state_nxt != ST_IDLE)) begin
            w_sp_nxt = (w_period_cnt_nxt < w_spw_sh_ext);
        end else begin
            w_sp_nxt = 1'b0;
        end

        // busy holds through the cycle that reports the final line
        w_busy_nxt = (w_state_nxt != ST_IDLE) || w_line_done;
    end

    // Counters and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_period_cnt <= CNT_ZERO;
            r_phase      <= 2'd0;
            r_line_cnt   <= CNT_ZERO;
            r_sp         <= 1'b0;
            r_pos_start  <= 1'b0;
            r_pos_frame  <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_period_cnt <= w_period_cnt_nxt;
            r_phase      <= w_phase_nxt;
            r_line_cnt   <= w_line_cnt_nxt;
            r_sp         <= w_sp_nxt;
            r_pos_start  <= w_pos_start_nxt;
            r_pos_frame  <= w_pos_frame_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_busy       <= w_busy_nxt;
            r_cfg_err    <= w_cfg_err_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    // Shadow configuration capture on an accepted start
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh_color  <= 1'b0;
            r_sh_cont   <= 1'b0;
            r_sh_period <= CNT_ZERO;
            r_sh_spw    <= {SPW_W{1'b0}};
            r_sh_lpf    <= CNT_ZERO;
        end else if (w_accept) begin
            r_sh_color  <= i_color_mode;
            r_sh_cont   <= i_continuous;
            r_sh_period <= i_line_period;
            r_sh_spw    <= i_sp_width;
            r_sh_lpf    <= i_lines_per_frame;
        end else begin
            r_sh_color  <= r_sh_color;
            r_sh_cont   <= r_sh_cont;
            r_sh_period <= r_sh_period;
            r_sh_spw    <= r_sh_spw;
            r_sh_lpf    <= r_sh_lpf;
        end
    end

    assign o_sp          = r_sp;
    assign o_pos_start   = r_pos_start;
    assign o_pos_frame   = r_pos_frame;
    assign o_color_phase = r_phase;
    assign o_line_cnt    = r_line_cnt;
    assign o_frame_done  = r_frame_done;
    assign o_busy        = r_busy;
    assign o_cfg_err     = r_cfg_err;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_cis_scan_scheduler.sv
// Directed testbench for cis_scan_scheduler. Index 0 in every observation
// window is the first cycle after the start request was clocked in.
module tb_cis_scan_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, continuous, color_mode, led_oe_n;
    logic [15:0] line_period, lines_per_frame;
    logic [7:0]  sp_width;
    logic        sp, pos_start, pos_frame, frame_done, busy, cfg_err, overrun;
    logic [1:0]  color_phase;
    logic [15:0] line_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Per-cycle samples of the current observation window
    bit          a_sp[256], a_pf[256], a_ps[256], a_fd[256], a_busy[256], a_ov[256], a_cfg[256];
    logic [15:0] a_lc[256];
    logic [1:0]  a_ph[256];
    logic [1:0]  rise_ph[8];
    int          n_rise, n_sp_hi, n_ps, n_pf, n_fd, fd_idx;

    cis_scan_scheduler dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_start           (start),
        .i_stop            (stop),
        .i_continuous      (continuous),
        .i_color_mode      (color_mode),
        .i_line_period     (line_period),
        .i_sp_width        (sp_width),
        .i_lines_per_frame (lines_per_frame),
        .i_led_oe_n        (led_oe_n),
        .o_sp              (sp),
        .o_pos_start       (pos_start),
        .o_pos_frame       (pos_frame),
        .o_color_phase     (color_phase),
        .o_line_cnt        (line_cnt),
        .o_frame_done      (frame_done),
        .o_busy            (busy),
        .o_cfg_err         (cfg_err),
        .o_overrun         (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Configure and pulse start; returns at the negedge of index 0
    task automatic apply_start(input logic cm, input logic cont, input logic [15:0] lp,
                               input logic [7:0] spw, input logic [15:0] lpf);
        @(negedge clk);
        color_mode = cm; continuous = cont; line_period = lp;
        sp_width = spw; lines_per_frame = lpf; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        color_mode = 1'b0; continuous = 1'b0; line_period = 16'd0;
        sp_width = 8'd0; lines_per_frame = 16'd0;
    endtask

    // Sample ncyc cycles; pulse stop after index stop_at; drive led low over [lo,hi]
    task automatic observe(input int ncyc, input int stop_at, input int lo, input int hi);
        bit prev_sp;
        prev_sp = 1'b0;
        n_rise = 0; n_sp_hi = 0; n_ps = 0; n_pf = 0; n_fd = 0; fd_idx = -1;
        for (int k = 0; k < ncyc; k++) begin
            a_sp[k] = sp; a_pf[k] = pos_frame; a_ps[k] = pos_start; a_fd[k] = frame_done;
            a_busy[k] = busy; a_ov[k] = overrun; a_cfg[k] = cfg_err;
            a_lc[k] = line_cnt; a_ph[k] = color_phase;
            if (sp && !prev_sp) begin
                if (n_rise < 8) rise_ph[n_rise] = color_phase;
                n_rise++;
            end
            if (sp) n_sp_hi++;
            if (pos_start) n_ps++;
            if (pos_frame) n_pf++;
            if (frame_done) begin
                if (fd_idx < 0) fd_idx = k;
                n_fd++;
            end
            prev_sp = sp;
            stop = (k == stop_at);
            led_oe_n = !((k >= lo) && (k <= hi));
            @(negedge clk);
        end
        stop = 1'b0;
        led_oe_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0; color_mode = 1'b0;
        led_oe_n = 1'b1; line_period = 16'd0; sp_width = 8'd0; lines_per_frame = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {sp, pos_start, pos_frame, frame_done, busy, cfg_err, overrun,
                                color_phase, line_cnt}, 32'd0);
        rst_n = 1'b1;

        // Gray, 20-cycle period, 4-cycle sp, 3 lines, single frame
        apply_start(1'b0, 1'b0, 16'd20, 8'd4, 16'd3);
        observe(100, -1, -1, -1);
        check("g_pos_start0", a_ps[0], 1);
        check("g_pos_frame0", a_pf[0], 1);
        check("g_sp0",        a_sp[0], 1);
        check("g_busy0",      a_busy[0], 1);
        check("g_sp3",        a_sp[3], 1);
        check("g_sp4",        a_sp[4], 0);
        check("g_sp20",       a_sp[20], 1);
        check("g_rises",      n_rise, 3);
        check("g_sp_hi",      n_sp_hi, 12);
        check("g_ps_count",   n_ps, 1);
        check("g_lc59",       a_lc[59], 2);
        check("g_fd_idx",     fd_idx, 60);
        check("g_fd_count",   n_fd, 1);
        check("g_lc60",       a_lc[60], 3);
        check("g_busy60",     a_busy[60], 1);
        check("g_busy61",     a_busy[61], 0);
        check("g_lc_hold",    a_lc[90], 3);
        check("g_ov",         a_ov[99], 0);

        // Colour, 10-cycle period, 2 lines
        apply_start(1'b1, 1'b0, 16'd10, 8'd2, 16'd2);
        observe(90, -1, -1, -1);
        check("c_rises",  n_rise, 6);
        check("c_phases", {rise_ph[0], rise_ph[1], rise_ph[2], rise_ph[3], rise_ph[4], rise_ph[5]},
                          {20'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2});
        check("c_lc29",   a_lc[29], 0);
        check("c_lc30",   a_lc[30], 1);
        check("c_ph30",   a_ph[30], 0);
        check("c_fd_idx", fd_idx, 60);
        check("c_fd_cnt", n_fd, 1);
        check("c_lc60",   a_lc[60], 2);
        check("c_ph_idle", a_ph[70], 0);

        // Overrun: exposure still active at the first period end
        apply_start(1'b0, 1'b0, 16'd20, 8'd4, 16'd2);
        observe(50, -1, 15, 22);
        check("o_ov19",  a_ov[19], 0);
        check("o_ov20",  a_ov[20], 1);
        check("o_ov_st", a_ov[49], 1);

        // Continuous gray, 2 lines per frame, stop during frame 3 line 1
        apply_start(1'b0, 1'b1, 16'd20, 8'd4, 16'd2);
        observe(140, 85, -1, -1);
        check("k_ov_clr",  a_ov[0], 0);
        check("k_pf40",    a_pf[40], 1);
        check("k_sp40",    a_sp[40], 1);
        check("k_sp39",    a_sp[39], 0);
        check("k_lc40",    a_lc[40], 2);
        check("k_lc41",    a_lc[41], 0);
        check("k_pf80",    a_pf[80], 1);
        check("k_pf_cnt",  n_pf, 3);
        check("k_ps_cnt",  n_ps, 1);
        check("k_fd_cnt",  n_fd, 2);
        check("k_lc100",   a_lc[100], 1);
        check("k_busy100", a_busy[100], 1);
        check("k_busy101", a_busy[101], 0);
        check("k_sp100",   a_sp[100], 0);
        check("k_rises",   n_rise, 5);

        // Rejected configurations
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: apply_start(1'b0, 1'b0, 16'd5,  8'd2,  16'd2);
                1: apply_start(1'b0, 1'b0, 16'd20, 8'd0,  16'd2);
                2: apply_start(1'b0, 1'b0, 16'd20, 8'd20, 16'd2);
                default: apply_start(1'b0, 1'b0, 16'd20, 8'd4, 16'd0);
            endcase
            observe(10, -1, -1, -1);
            check($sformatf("bad%0d_cfg0", c),  a_cfg[0], 1);
            check($sformatf("bad%0d_cfg1", c),  a_cfg[1], 0);
            check($sformatf("bad%0d_busy", c),  a_busy[0], 0);
            check($sformatf("bad%0d_rises", c), n_rise, 0);
        end

        // Boundary: minimum period with widest legal sp, single line
        apply_start(1'b0, 1'b0, 16'd8, 8'd7, 16'd1);
        observe(20, -1, -1, -1);
        check("m_cfg0",   a_cfg[0], 0);
        check("m_sp_hi",  n_sp_hi, 7);
        check("m_sp7",    a_sp[7], 0);
        check("m_fd_idx", fd_idx, 8);
        check("m_lc8",    a_lc[8], 1);

        // Asynchronous reset in the middle of a scan
        apply_start(1'b0, 1'b0, 16'd8, 8'd6, 16'd4);
        observe(20, -1, 5, 9);
        check("r_lc19", a_lc[19], 2);
        check("r_ov19", a_ov[19], 1);
        check("r_sp_pre", sp, 1);
        #2 rst_n = 1'b0;
        #1;
        check("r_sp",   sp, 0);
        check("r_busy", busy, 0);
        check("r_lc",   line_cnt, 0);
        check("r_ov",   overrun, 0);
        check("r_fd",   frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_start(1'b0, 1'b0, 16'd20, 8'd4, 16'd3);
        observe(30, -1, -1, -1);
        check("r2_ps0", a_ps[0], 1);
        check("r2_sp0", a_sp[0], 1);
        check("r2_lc20", a_lc[20], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cis_scan_scheduler.md
Name: cis_scan_scheduler

Overview:
- Line/frame sequencer that drives the CIS exposure controller.
- Generates the sensor start pulse `sp`, plus the `pos_start` and `pos_frame` strobes.
- Steps R/G/B phases in colour mode and counts lines per frame.
- Monitors exposure completion (`led_oe_n`) to flag line-period overruns; sits between the register file / DMA control and the exposure block.

Parameters:
- CNT_W, 16, width of the period and line counters and their config inputs.
- SPW_W, 8, width of the `sp` pulse-width config.
- MIN_PERIOD, 8, minimum legal `line_period` in clk cycles.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  1-cycle request to begin a scan (sampled in IDLE only)
- stop  input  1  1-cycle request to end the scan after the current line
- continuous  input  1  1 = restart a new frame automatically after the last line
- color_mode  input  1  1 = 3 `sp` periods per line (R,G,B); 0 = 1 per line (gray)
- line_period  input  CNT_W  clk cycles per `sp` period
- sp_width  input  SPW_W  `sp` high time in cycles
- lines_per_frame  input  CNT_W  lines per frame
- led_oe_n  input  1  exposure active-low, from the exposure block
- sp  output  1  sensor start pulse / exposure trigger
- pos_start  output  1  1-cycle scan-start strobe
- pos_frame  output  1  1-cycle frame-start strobe
- color_phase  output  2  0=R, 1=G, 2=B (always 0 in gray)
- line_cnt  output  CNT_W  lines completed in the current frame
- frame_done  output  1  1-cycle strobe at the end of the last line of a frame
- busy  output  1  high in any state other than IDLE
- cfg_err  output  1  1-cycle strobe when `start` is rejected
- overrun  output  1  sticky: exposure still active at a period end

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; all counters 0; shadow registers 0.
- States: IDLE, RUN, STOPPING.
- IDLE + start:
  - Reject if `line_period < MIN_PERIOD`, `sp_width == 0`, `sp_width >= line_period`, or `lines_per_frame == 0`. A reject gives `cfg_err=1` for 1 cycle next clk; stay IDLE.
  - Otherwise: latch `color_mode`, `line_period`, `sp_width`, `lines_per_frame`, `continuous` into shadow registers.
  - Next clk: RUN; `pos_start=1`, `pos_frame=1` (1 cycle each); `period_cnt=0`; `color_phase=0`; `line_cnt=0`; `overrun` cleared.
- Config inputs are ignored outside that latch cycle.
- RUN:
  - `period_cnt` counts 0..`line_period`-1, then wraps to 0.
  - `sp = (period_cnt < sp_width)`, registered, so it is high in the same cycle as `period_cnt=0`. The first `sp` high coincides with `pos_start`/`pos_frame`.
- Period end (`period_cnt == line_period-1`):
  - Colour mode:
    - `color_phase` advances 0→1→2.
    - At phase 2 the line completes: `line_cnt+1`, `color_phase←0`.
  - Gray mode: every period completes a line.
  - If `led_oe_n==0` at a period end, set `overrun=1` (sticky until the next accepted start).
- Line completion with `line_cnt+1 == lines_per_frame`:
  - `frame_done=1` for 1 cycle (same cycle `line_cnt` shows the final value).
  - If shadow `continuous=1` and no stop is pending: `line_cnt←0`; next cycle `pos_frame=1` with the new period's first `sp` (no gap). `pos_start` is not repeated.
  - Otherwise go to IDLE; `busy` drops next cycle.
- `stop` in RUN: go to STOPPING.
- STOPPING:
  - Identical counting to RUN.
  - Exit to IDLE at the next line completion.
  - `frame_done` pulses only if that line is the frame's last.
  - `sp` never rises after the line completes.
- Simultaneous events:
  - stop and line completion in the same cycle: complete the line, go directly to IDLE.
  - start outside IDLE: ignored.
  - stop in IDLE: ignored.
- In IDLE, `line_cnt` holds its last value and `color_phase` holds 0.
- Reset mid-scan: everything returns to reset values immediately; no `frame_done` pulse.

Test Plan:
- Gray, `line_period`=20, `sp_width`=4, `lines_per_frame`=3, `continuous`=0, start → `pos_start`/`pos_frame` 1 clk after start; `sp` high 4 of every 20 clks, 3 pulses total. `frame_done` 60 clks after the first `sp`; `line_cnt`=3; `busy` low next clk.
- Colour, `line_period`=10, `sp_width`=2, `lines_per_frame`=2 → 6 `sp` pulses; `color_phase` sequence 0,1,2,0,1,2; `line_cnt` increments only after each phase-2 period; one `frame_done`.
- `continuous`=1, gray, `lines_per_frame`=2 → `pos_frame` every 40 clks aligned with the `sp` rise; `pos_start` once. Stop mid-line 1 → finishes that line, `busy` falls; no further `sp`.
- Bad config: `line_period`=5, or `sp_width`=0, or `sp_width`=`line_period` → `cfg_err` 1-cycle pulse; `busy` stays 0; no `sp`.
- Overrun: hold `led_oe_n`=0 across a period end → `overrun`=1 and stays 1; a new accepted start clears it.
- Reset asserted mid-RUN (async, between clk edges) → `sp`, `busy`, `line_cnt`, `overrun` all 0 immediately; after release, start works normally.
